pfet_gate_driver: RTL and testbench
===================================

# pfet_gate_driver

Clocked gate driver that converts a digital drive code into the piecewise-linear gate voltage of the mLingua PMOS DC model, directly upstream of its `g` terminal. Each accepted code produces a linear ramp of the gate voltage from the current level to the coded target over a programmed number of clock cycles, then holds it. A valid/ready request handshake sets the code, and a synchronous `off` input forces the device off.

## Interface
- `N_BITS`, 6: drive code width.
- `VDD`, 1.0: source-side supply in volts; gate level for code 0 (device off).
- `RAMP_CYC`, 4: clock cycles per transition; legal range 1 to 255; 0 is a fatal elaboration error.
- `TCLK`, 1e-9: clock period in seconds; used only for slope computation.

Ports:
- `clk`  input  1  clock; all state changes on its rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `off`  input  1  synchronous force-off, level sensitive.
- `req_valid`  input  1  request present.
- `req_ready`  output  1  request can be accepted this cycle.
- `code`  input  N_BITS  requested drive code; sampled when `req_valid && req_ready`.
- `busy`  output  1  ramp in progress.
- `done`  output  1  one-cycle pulse when the target is reached.
- `cur_code`  output  N_BITS  code of the last reached or currently targeted level.
- `g`  output  pwl  gate voltage to the PMOS model, as value, slope (V/s) and t0 (s).

## Operation
- Target level: `VLSB = VDD/2**N_BITS`, `v(code) = VDD - code*VLSB`. Arithmetic is real. Code is unsigned.
- Ramp slope: `(v_target - v_start)/(RAMP_CYC*TCLK)`.
- t0 is `$realtime` at the edge, scaled by the codebase timeunit macro.
- States:
  - IDLE: `req_ready=1`, `busy=0`, `g` is constant.
  - RAMP: `busy=1`, a down-counter is loaded with RAMP_CYC.
- IDLE to RAMP:
  - Occurs on an accept edge when the code differs from `cur_code`.
  - `g` becomes `'{v_start, slope, t_edge}`.
  - `cur_code` takes the new code.
- Same-code accept: stays in IDLE, `g` is unchanged, `done` pulses on the next cycle.
- RAMP to IDLE:
  - Occurs on the edge where the counter reaches 0.
  - `g` becomes `'{v_target, 0, t_edge}` exactly, so it never drifts.
  - `done` is 1 for that cycle.
- `g` is written only at ramp start and ramp end. No per-cycle re-anchoring.
- `off=1` on an edge:
  - Forces the state to IDLE, `g='{VDD,0,t_edge}` and `cur_code=0`.
  - Clears the counter and any pending request. No `done` pulse.
  - `req_ready=0` while `off` is high.
- Priority: `rst` > `off` > ramp completion > request accept.

## Timing
- Reset values: state IDLE, `g='{VDD,0,t_edge}`, `cur_code=0`, `busy=0`, `done=0`, `req_ready=0` during reset and 1 from the first cycle after.
- Reset mid-ramp aborts the ramp immediately on that edge.
- Accept at edge k gives ramp end and `done` at edge k+RAMP_CYC. Earliest next accept is also at edge k+RAMP_CYC: completion and accept on the same edge chain the ramps, starting from the reached target.
- `busy` is high from edge k to edge k+RAMP_CYC, exclusive of the end.
- Outputs are registered. No combinational path from inputs to `g`.

## Configuration
- `PFET_GATE_DRV_QUEUE_EN` defined:
  - A one-entry request buffer keeps `req_ready=1` during RAMP while the buffer is empty.
  - A buffered code starts its ramp on the completion edge, with `v_start` equal to the previous target.
  - The buffer is cleared by `off` and `rst`.
- Not defined: `req_ready=0` throughout RAMP.

## Structure
- Package `pfet_gate_drv_pkg`:
  - State enum.
  - `RAMP_CNT_W=8`.
  - Function `code2v(code, VDD, N_BITS)`.
- The pwl typedef comes from the existing mLingua package. It is not redefined.
- Sub-module `pfet_gate_req_buf`: the one-entry buffer, instantiated only under the macro.

## Test plan
- Reset with `N_BITS=6`, `VDD=1.0`, `RAMP_CYC=4` → `g={1.0,0,t}`, `cur_code=0`, `req_ready=1` one cycle after reset release.
- Accept code 32 at edge k:
  - Edge k: `g={1.0,-1.25e8,t_k}`.
  - Edge k+4: `g={0.5,0,t}` and `done=1`.
  - The downstream pfet reaches 0.5 V.
- Accept code 32 again → no ramp, `done` one cycle later, `g` unchanged.
- `off` asserted two cycles into a 0→63 ramp → `g={1.0,0,t}`, `busy=0`, no `done`, `cur_code=0`.
- Without the macro, `req_valid` held during a ramp → `req_ready=0` until the completion edge. A code 16 then chains, starting at the previous target with slope `(0.75-v_prev)/4ns`.
- With the macro:
  - Codes 63 and 0 are both accepted back-to-back.
  - `done` pulses at k+4 and k+8.
  - Final `g={1.0,0,t}`.
  - A third request sees `req_ready=0` while the buffer is full.

Source files
------------

// File: rtl/mLingua_pwl_pkg.sv
`timescale 1ns/1ps
// Piecewise-linear signal type shared with the mLingua behavioural models.
// Supplied here only so this slice builds standalone.
package mLingua_pwl_pkg;
   typedef struct {
      real a;   // value at t0 (V)
      real b;   // slope (V/s)
      real t0;  // anchor time (s)
   } pwl;
endpackage

// File: rtl/pfet_gate_drv_pkg.sv
`timescale 1ns/1ps
// Types and helpers for the PMOS gate driver: FSM state, counter width,
// and the drive-code to gate-voltage mapping.
package pfet_gate_drv_pkg;
   typedef enum logic {ST_IDLE, ST_RAMP} drv_state_e;

   localparam int unsigned RAMP_CNT_W = 8;

   function automatic real code2v(input int unsigned code, input real vdd,
                                  input int unsigned n_bits);
      real vlsb;
      vlsb = vdd / real'(longint'(1) << n_bits);
      return vdd - real'(code) * vlsb;
   endfunction
endpackage

// File: rtl/pfet_gate_req_buf.sv
`timescale 1ns/1ps
// One-entry request buffer that holds a drive code accepted mid-ramp
// until the running ramp completes.
module pfet_gate_req_buf #(
   parameter int unsigned N_BITS = 6
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [N_BITS-1:0] code_i,
   output logic              full_o,
   output logic [N_BITS-1:0] code_o
);
   logic              full_q, full_d;
   logic [N_BITS-1:0] code_q, code_d;

   always_comb begin
      full_d = full_q;
      code_d = code_q;
      if (clr_i || pop_i) begin
         full_d = 1'b0;
      end else if (push_i) begin
         full_d = 1'b1;
         code_d = code_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         full_q <= 1'b0;
         code_q <= '0;
      end else begin
         full_q <= full_d;
         code_q <= code_d;
      end
   end

   assign full_o = full_q;
   assign code_o = code_q;
endmodule

// File: rtl/pfet_gate_driver.sv
`timescale 1ns/1ps
// Clocked PMOS gate driver producing a pwl gate voltage that ramps to the
// coded level. Define PFET_GATE_DRV_QUEUE_EN to buffer one request mid-ramp.
`ifndef MLINGUA_TIMEUNIT
`define MLINGUA_TIMEUNIT 1e-9
`endif

module pfet_gate_driver
   import pfet_gate_drv_pkg::*;
   import mLingua_pwl_pkg::*;
#(
   parameter int unsigned N_BITS   = 6,
   parameter real         VDD      = 1.0,
   parameter int unsigned RAMP_CYC = 4,
   parameter real         TCLK     = 1e-9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              off,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [N_BITS-1:0] code,
   output logic              busy,
   output logic              done,
   output logic [N_BITS-1:0] cur_code,
   output pwl                g
);
   if (RAMP_CYC < 1 || RAMP_CYC > 255) begin : g_bad_ramp
      $fatal(1, "pfet_gate_driver: RAMP_CYC must be 1..255");
   end

   localparam logic [RAMP_CNT_W-1:0] CNT_LOAD = RAMP_CNT_W'(RAMP_CYC);
   localparam logic [RAMP_CNT_W-1:0] CNT_ONE  = RAMP_CNT_W'(1);
   localparam real                   RAMP_T   = real'(RAMP_CYC) * TCLK;

   drv_state_e              state_q, state_d;
   logic [RAMP_CNT_W-1:0]   cnt_q, cnt_d;
   logic [N_BITS-1:0]       cur_q, cur_d;
   logic                    done_q, done_d;
   logic                    rdy_en_q;
   pwl                      g_q;
   logic                    g_wr;
   real                     g_a_d, g_b_d;
   logic                    accept, ramp_end, ramp_rdy;
   logic                    nxt_valid;
   logic [N_BITS-1:0]       nxt_code;

`ifdef PFET_GATE_DRV_QUEUE_EN
   logic                    buf_full, buf_push, buf_pop;
   logic [N_BITS-1:0]       buf_code;

   pfet_gate_req_buf #(.N_BITS(N_BITS)) u_req_buf (
      .clk_i  (clk),
      .rst_i  (rst),
      .clr_i  (off),
      .push_i (buf_push),
      .pop_i  (buf_pop),
      .code_i (code),
      .full_o (buf_full),
      .code_o (buf_code)
   );

   assign ramp_rdy = !buf_full;
`else
   // Ready in the final ramp cycle so an accept can chain on the completion edge.
   assign ramp_rdy = (cnt_q == CNT_ONE);
`endif

   assign ramp_end  = (state_q == ST_RAMP) && (cnt_q == CNT_ONE);
   assign req_ready = rdy_en_q && !off && ((state_q == ST_IDLE) || ramp_rdy);
   assign accept    = req_valid && req_ready;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cur_d     = cur_q;
      done_d    = 1'b0;
      g_wr      = 1'b0;
      g_a_d     = g_q.a;
      g_b_d     = g_q.b;
      nxt_valid = 1'b0;
      nxt_code  = code;
`ifdef PFET_GATE_DRV_QUEUE_EN
      buf_push  = 1'b0;
      buf_pop   = 1'b0;
`endif
      if (off) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         cur_d   = '0;
         g_wr    = 1'b1;
         g_a_d   = VDD;
         g_b_d   = 0.0;
      end else begin
         if (state_q == ST_RAMP) begin
            if (ramp_end) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
               g_wr    = 1'b1;
               g_a_d   = code2v(32'(cur_q), VDD, N_BITS);
               g_b_d   = 0.0;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
`ifdef PFET_GATE_DRV_QUEUE_EN
         if (ramp_end && buf_full) begin
            nxt_valid = 1'b1;
            nxt_code  = buf_code;
            buf_pop   = 1'b1;
         end else if (accept && (state_q == ST_IDLE || ramp_end)) begin
            nxt_valid = 1'b1;
         end else if (accept) begin
            buf_push = 1'b1;
         end
`else
         nxt_valid = accept;
`endif
         // A new ramp always starts from the last reached target level.
         if (nxt_valid) begin
            if (nxt_code != cur_q) begin
               state_d = ST_RAMP;
               cnt_d   = CNT_LOAD;
               cur_d   = nxt_code;
               g_wr    = 1'b1;
               g_a_d   = code2v(32'(cur_q), VDD, N_BITS);
               g_b_d   = (code2v(32'(nxt_code), VDD, N_BITS) - g_a_d) / RAMP_T;
            end else begin
               done_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         cur_q    <= '0;
         done_q   <= 1'b0;
         rdy_en_q <= 1'b0;
         g_q.a    <= VDD;
         g_q.b    <= 0.0;
         g_q.t0   <= $realtime * `MLINGUA_TIMEUNIT;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cur_q    <= cur_d;
         done_q   <= done_d;
         rdy_en_q <= 1'b1;
         if (g_wr) begin
            g_q.a  <= g_a_d;
            g_q.b  <= g_b_d;
            g_q.t0 <= $realtime * `MLINGUA_TIMEUNIT;
         end
      end
   end

   assign busy     = (state_q == ST_RAMP);
   assign done     = done_q;
   assign cur_code = cur_q;
   assign g        = g_q;
endmodule

// File: tb/tb_pfet_gate_driver.sv
`timescale 1ns/1ps
// Directed vector bench for pfet_gate_driver (N_BITS=6, VDD=1.0, RAMP_CYC=4, 1 ns clock).
module tb_pfet_gate_driver;
   import mLingua_pwl_pkg::*;

`ifdef PFET_GATE_DRV_QUEUE_EN
   localparam logic QR = 1'b1;
`else
   localparam logic QR = 1'b0;
`endif

   localparam real V63 = 1.0 - 63.0 / 64.0;

   typedef struct {
      logic       off;
      logic       vld;
      logic [5:0] code;
      logic       rdy;
      logic       busy;
      logic       done;
      logic [5:0] cur;
      real        a;
      real        b;
      logic       newt;
   } vec_t;

   logic       clk;
   logic       rst, off, req_valid, req_ready, busy, done;
   logic [5:0] code_in, cur_code;
   pwl         g;

   int   checks   = 0;
   int   failures = 0;
   real  edge_t   = 0.0;
   real  exp_t0   = 0.0;
   vec_t vecs[$];

   pfet_gate_driver #(
      .N_BITS   (6),
      .VDD      (1.0),
      .RAMP_CYC (4),
      .TCLK     (1e-9)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .off       (off),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .code      (code_in),
      .busy      (busy),
      .done      (done),
      .cur_code  (cur_code),
      .g         (g)
   );

   initial begin
      clk = 1'b0;
      forever #0.5 clk = ~clk;
   end

   always @(posedge clk) edge_t = $realtime * 1e-9;

   function automatic void add(input logic o, input logic v, input logic [5:0] c,
                               input logic r, input logic bz, input logic d,
                               input logic [5:0] cu, input real a, input real b,
                               input logic nt);
      vec_t e;
      e.off = o; e.vld = v; e.code = c; e.rdy = r; e.busy = bz; e.done = d;
      e.cur = cu; e.a = a; e.b = b; e.newt = nt;
      vecs.push_back(e);
   endfunction

   task automatic chk_bit(input string name, input int step, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step %0d: got %b want %b", name, step, act, exp);
      end
   endtask

   task automatic chk_code(input string name, input int step, input logic [5:0] act,
                           input logic [5:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step %0d: got %0d want %0d", name, step, act, exp);
      end
   endtask

   task automatic chk_real(input string name, input int step, input real act, input real exp);
      real diff, tol;
      diff = act - exp;
      if (diff < 0.0) diff = -diff;
      tol = (exp < 0.0 ? -exp : exp) * 1e-9 + 1e-15;
      checks++;
      if (diff > tol) begin
         failures++;
         $display("FAIL %s step %0d: got %g want %g", name, step, act, exp);
      end
   endtask

   task automatic chk_outs(input int step, input logic bz, input logic d, input logic [5:0] cu,
                           input real a, input real b);
      chk_bit ("busy",     step, busy, bz);
      chk_bit ("done",     step, done, d);
      chk_code("cur_code", step, cur_code, cu);
      chk_real("g.a",      step, g.a, a);
      chk_real("g.b",      step, g.b, b);
      chk_real("g.t0",     step, g.t0, exp_t0);
   endtask

   initial begin
      rst = 1'b1; off = 1'b0; req_valid = 1'b0; code_in = '0;

      //  off vld code rdy busy done cur  a       b              newt
      add(0, 1, 32, 1,  1, 0, 32, 1.0,  -1.25e8,          1);  // accept 32 at k
      add(0, 0,  0, QR, 1, 0, 32, 1.0,  -1.25e8,          0);
      add(0, 0,  0, QR, 1, 0, 32, 1.0,  -1.25e8,          0);
      add(0, 0,  0, QR, 1, 0, 32, 1.0,  -1.25e8,          0);
      add(0, 0,  0, 1,  0, 1, 32, 0.5,   0.0,             1);  // k+4 complete
      add(0, 0,  0, 1,  0, 0, 32, 0.5,   0.0,             0);
      add(0, 1, 32, 1,  0, 1, 32, 0.5,   0.0,             0);  // same code
      add(0, 0,  0, 1,  0, 0, 32, 0.5,   0.0,             0);
      add(1, 0,  0, 0,  0, 0,  0, 1.0,   0.0,             1);  // off from idle
      add(0, 0,  0, 1,  0, 0,  0, 1.0,   0.0,             0);
      add(0, 1, 63, 1,  1, 0, 63, 1.0,  (V63-1.0)/4e-9,   1);  // 0 -> 63
      add(0, 0,  0, QR, 1, 0, 63, 1.0,  (V63-1.0)/4e-9,   0);
      add(0, 0,  0, QR, 1, 0, 63, 1.0,  (V63-1.0)/4e-9,   0);
      add(1, 1,  5, 0,  0, 0,  0, 1.0,   0.0,             1);  // off mid-ramp
      add(0, 0,  0, 1,  0, 0,  0, 1.0,   0.0,             0);
      add(0, 0,  0, 1,  0, 0,  0, 1.0,   0.0,             0);
`ifdef PFET_GATE_DRV_QUEUE_EN
      add(0, 1, 63, 1,  1, 0, 63, 1.0,  (V63-1.0)/4e-9,   1);  // 63 at k
      add(0, 1,  0, 1,  1, 0, 63, 1.0,  (V63-1.0)/4e-9,   0);  // 0 buffered
      add(0, 1, 10, 0,  1, 0, 63, 1.0,  (V63-1.0)/4e-9,   0);  // buffer full
      add(0, 1, 10, 0,  1, 0, 63, 1.0,  (V63-1.0)/4e-9,   0);
      add(0, 1, 10, 0,  1, 1,  0, V63,  (1.0-V63)/4e-9,   1);  // k+4 chain
      add(0, 0,  0, 1,  1, 0,  0, V63,  (1.0-V63)/4e-9,   0);
      add(0, 0,  0, 1,  1, 0,  0, V63,  (1.0-V63)/4e-9,   0);
      add(0, 0,  0, 1,  1, 0,  0, V63,  (1.0-V63)/4e-9,   0);
      add(0, 0,  0, 1,  0, 1,  0, 1.0,   0.0,             1);  // k+8 complete
      add(0, 0,  0, 1,  0, 0,  0, 1.0,   0.0,             0);
`else
      add(0, 1, 32, 1,  1, 0, 32, 1.0,  -1.25e8,          1);
      add(0, 1, 16, 0,  1, 0, 32, 1.0,  -1.25e8,          0);  // held, not ready
      add(0, 1, 16, 0,  1, 0, 32, 1.0,  -1.25e8,          0);
      add(0, 1, 16, 0,  1, 0, 32, 1.0,  -1.25e8,          0);
      add(0, 1, 16, 1,  1, 1, 16, 0.5,  (0.75-0.5)/4e-9,  1);  // chained accept
      add(0, 0,  0, 0,  1, 0, 16, 0.5,  (0.75-0.5)/4e-9,  0);
      add(0, 0,  0, 0,  1, 0, 16, 0.5,  (0.75-0.5)/4e-9,  0);
      add(0, 0,  0, 0,  1, 0, 16, 0.5,  (0.75-0.5)/4e-9,  0);
      add(0, 0,  0, 1,  0, 1, 16, 0.75,  0.0,             1);
      add(0, 0,  0, 1,  0, 0, 16, 0.75,  0.0,             0);
`endif

      repeat (2) @(posedge clk);
      @(negedge clk);
      exp_t0 = edge_t;
      chk_bit("rst_ready", -1, req_ready, 1'b0);
      chk_outs(-1, 1'b0, 1'b0, 6'd0, 1.0, 0.0);

      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk_bit("post_rst_ready", 0, req_ready, 1'b1);
      chk_outs(0, 1'b0, 1'b0, 6'd0, 1.0, 0.0);

      for (int unsigned i = 0; i < vecs.size(); i++) begin
         off       = vecs[i].off;
         req_valid = vecs[i].vld;
         code_in   = vecs[i].code;
         #0.1;
         chk_bit("req_ready", int'(i) + 1, req_ready, vecs[i].rdy);
         @(posedge clk);
         @(negedge clk);
         if (vecs[i].newt) exp_t0 = edge_t;
         chk_outs(int'(i) + 1, vecs[i].busy, vecs[i].done, vecs[i].cur, vecs[i].a, vecs[i].b);
      end

      off = 1'b0; req_valid = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
